sync_8x8_fifo: RTL and testbench

Single-clock 8-entry × 8-bit first-in/first-out buffer with full, empty, almost-full and almost-empty status flags and overrun/underrun error detection. It sits between a producer and a consumer that share one clock domain. It absorbs short bursts of writes, then returns the data in order to the reader.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_8x8_fifo.sv | 103 ++++++++++
 tb/tb_sync_8x8_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared constants and types for the single-clock 8x8 FIFO.
//   FIFO_DATA_WIDTH / FIFO_DEPTH give the default geometry; FIFO_ADDR_W is
//   the storage index width. fifo_ptr_t carries one extra wrap bit above the
//   index so that full and empty can be told apart when the indices match.
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_ADDR_W     = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_ADDR_W:0]       fifo_ptr_t;

endpackage

// File: rtl/sync_8x8_fifo.sv
// sync_8x8_fifo
//   Single-clock FIFO (DEPTH entries x DATA_WIDTH bits) with registered
//   read data, full/empty/almost-full/almost-empty flags and overrun/underrun
//   error registers.
//
// Ports
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous active-high reset
//   we / w_data  - write request and write data
//   re           - read request
//   r_data       - registered read data, valid right after the sampling edge
//   full         - count == DEPTH
//   empty        - count == 0
//   almost_full  - count == DEPTH-1
//   almost_empty - count == 1
//
// Configuration macro
//   SYNC_FIFO_STICKY_ERR_EN - when defined, overrun/underrun stay set until
//   rst; otherwise each is a one-cycle pulse after the offending edge.
module sync_8x8_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ALMOST_FL = (ADDR_W+1)'(DEPTH - 1);

`ifdef SYNC_FIFO_STICKY_ERR_EN
  localparam logic STICKY_ERR = 1'b1;
`else
  localparam logic STICKY_ERR = 1'b0;
`endif

  // Pointers: low ADDR_W bits index storage, MSB is the wrap bit.
  logic [ADDR_W:0]         wp;
  logic [ADDR_W:0]         rp;
  logic [ADDR_W:0]         count;
  logic [DATA_WIDTH-1:0]   fifo [0:DEPTH-1];
  logic                    overrun;
  logic                    underrun;
  logic                    do_write;
  logic                    do_read;

  // Occupancy and status flags, purely from the pointers.
  always_comb begin
    count        = wp - rp;
    empty        = (wp == rp);
    full         = (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]) && (wp[ADDR_W] != rp[ADDR_W]);
    almost_full  = (count == CNT_ALMOST_FL);
    almost_empty = (count == PTR_ONE);
  end

  // Each side is gated by its own pre-edge flag, so a simultaneous request
  // on a full FIFO still reads and on an empty FIFO still writes.
  always_comb begin
    do_write = we && !full;
    do_read  = re && !empty;
  end

  // Storage array: not reset, entries persist until overwritten.
  always_ff @(posedge clk) begin
    if (do_write) begin
      fifo[wp[ADDR_W-1:0]] <= w_data;
    end
  end

  // Pointers, registered read data and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      r_data   <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (do_write) begin
        wp <= wp + PTR_ONE;
      end
      if (do_read) begin
        r_data <= fifo[rp[ADDR_W-1:0]];
        rp     <= rp + PTR_ONE;
      end
      // STICKY_ERR folds the hold term away in the pulse build.
      overrun  <= (we && full)  || (STICKY_ERR && overrun);
      underrun <= (re && empty) || (STICKY_ERR && underrun);
    end
  end

endmodule

// File: tb/tb_sync_8x8_fifo.sv
// tb_sync_8x8_fifo
//   Scenario-based bench for sync_8x8_fifo. A queue scoreboard holds every
//   accepted write; accepted reads pop from it and the popped word is
//   compared with r_data right after the edge. An occupancy model supplies
//   the expected flags and error bits.
module tb_sync_8x8_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic       re;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;

  int         passed = 0;
  int         total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_r;
  int         mcount;
  bit         exp_ov;
  bit         exp_un;

  sync_8x8_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .re           (re),
    .w_data       (w_data),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // Expected {full, empty, almost_full, almost_empty, overrun, underrun}.
  function automatic logic [5:0] exp_flags();
    return {mcount == 8, mcount == 0, mcount == 7, mcount == 1, exp_ov, exp_un};
  endfunction

  function automatic logic [5:0] dut_flags();
    return {full, empty, almost_full, almost_empty, dut.overrun, dut.underrun};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mcount = 0;
    last_r = 8'h00;
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask

  // One clock of stimulus; the scoreboard checks r_data after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit         wr_ok;
    bit         rd_ok;
    logic [7:0] exp_d;
    we     = w;
    re     = r;
    w_data = d;
    wr_ok  = w && (mcount < 8);
    rd_ok  = r && (mcount > 0);
    exp_d  = last_r;
    if (rd_ok) exp_d = exp_q.pop_front();
    @(posedge clk);
    #1;
    if (wr_ok) exp_q.push_back(d);
    mcount = mcount + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
`ifdef SYNC_FIFO_STICKY_ERR_EN
    exp_ov = exp_ov || (w && !wr_ok);
    exp_un = exp_un || (r && !rd_ok);
`else
    exp_ov = w && !wr_ok;
    exp_un = r && !rd_ok;
`endif
    we = 1'b0;
    re = 1'b0;
    total++;
    if (r_data !== exp_d) $display("FAIL r_data: got %h expected %h", r_data, exp_d);
    else passed++;
    last_r = exp_d;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    w_data = 8'h00;
    repeat (3) begin
      we = 1'($urandom_range(1, 0));
      re = 1'($urandom_range(1, 0));
      @(posedge clk);
    end
    #1;
    model_reset();
    total++;
    if ({dut.wp, dut.rp, r_data} !== {4'd0, 4'd0, 8'h00})
      $display("FAIL reset_state: got wp=%0d rp=%0d r_data=%h expected 0 0 00", dut.wp, dut.rp, r_data);
    else passed++;
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL reset_flags: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
    @(negedge clk);
    we  = 1'b0;
    re  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, (i == 8) ? 8'hAA : 8'(8'h10 + i));
      total++;
      if (dut_flags() !== exp_flags())
        $display("FAIL fill_flags i=%0d: got %b expected %b", i, dut_flags(), exp_flags());
      else passed++;
      if (i == 6) begin
        total++;
        if (dut.wp !== 4'd7) $display("FAIL fill_wp7: got %0d expected 7", dut.wp);
        else passed++;
      end
    end
    total++;
    if ({dut.wp, dut.fifo[0]} !== {4'd8, 8'h10})
      $display("FAIL overrun_state: got wp=%0d fifo0=%h expected 8 10", dut.wp, dut.fifo[0]);
    else passed++;
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL overrun_clear: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (dut_flags() !== exp_flags())
        $display("FAIL drain_flags i=%0d: got %b expected %b", i, dut_flags(), exp_flags());
      else passed++;
    end
    total++;
    if (r_data !== 8'h17) $display("FAIL underrun_hold: got %h expected 17", r_data);
    else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'(8'h50 + i));
      total++;
      if (dut_flags() !== exp_flags())
        $display("FAIL wrap_wr_flags i=%0d: got %b expected %b", i, dut_flags(), exp_flags());
      else passed++;
    end
    total++;
    if (dut.wp !== 4'd3) $display("FAIL wrap_wp: got %0d expected 3", dut.wp);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (dut_flags() !== exp_flags())
        $display("FAIL wrap_rd_flags i=%0d: got %b expected %b", i, dut_flags(), exp_flags());
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i));
      total++;
      if (4'(dut.wp - dut.rp) !== 4'd3)
        $display("FAIL simul_count i=%0d: got %0d expected 3", i, 4'(dut.wp - dut.rp));
      else passed++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h90);
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL simul_empty: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    step(1'b1, 1'b1, 8'hBB);
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL simul_full: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({dut.wp, dut.rp, r_data} !== {4'd0, 4'd0, 8'h00})
      $display("FAIL async_state: got wp=%0d rp=%0d r_data=%h expected 0 0 00", dut.wp, dut.rp, r_data);
    else passed++;
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL async_flags: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (dut_flags() !== exp_flags())
      $display("FAIL async_read_empty: got %b expected %b", dut_flags(), exp_flags());
    else passed++;
  endtask

  initial begin
    we     = 1'b0;
    re     = 1'b0;
    w_data = 8'h00;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
